// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants for the instruction-fetch stage
//
// Purpose: reset/exception PC values, legal instruction-memory window,
//          fetch exception code and PCSrc encodings used by fetch and decode.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_LO     = 32'h0000_3000;
  localparam logic [31:0] IM_HI     = 32'h0000_6FFC;

  localparam int          EXC_W     = 5;
  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  // PCSrc encodings driven by decode; 2'd3 is unused and behaves as PC+4.
  localparam logic [1:0]  PCSRC_PC4 = 2'd0;
  localparam logic [1:0]  PCSRC_NPC = 2'd1;
  localparam logic [1:0]  PCSRC_REG = 2'd2;

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// rtl/fetch_stage_fd_reg.sv - F/D pipeline register with reset/flush/stall priority
//
// Purpose: registers the fetched instruction, PC+4 and fetch exception code
//          for decode. Priority: reset, flush, stall (hold), load.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_flush, i_stall     flush to a nop bubble / hold current contents
//   i_instr, i_pc4, i_exc   values loaded when neither flushing nor stalled
//   o_instr, o_pc4, o_exc   registered outputs
module fd_reg
  import fetch_stage_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_stall,
  input  logic [31:0]      i_instr,
  input  logic [31:0]      i_pc4,
  input  logic [EXC_W-1:0] i_exc,
  output logic [31:0]      o_instr,
  output logic [31:0]      o_pc4,
  output logic [EXC_W-1:0] o_exc
);

  logic [31:0]      r_instr;
  logic [31:0]      r_pc4;
  logic [EXC_W-1:0] r_exc;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_instr <= 32'd0;
      r_pc4   <= 32'd0;
      r_exc   <= EXC_NONE;
    end else if (!i_stall) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_exc   <= i_exc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_exc   = r_exc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, next-PC select, AdEL check, F/D register
//
// Purpose: holds the PC, picks the next PC from decode redirects and CP0
//          exception/eret controls, flags illegal fetch addresses as AdEL and
//          feeds decode through the F/D register.
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   InstrF              instruction word read combinationally from IM at PCF
//   PCSrc, NPCOut, ForwardD1   decode redirect request and targets
//   Stall               hold PC and F/D register
//   ExcEnter, Eret, EPC CP0 exception entry / exception return
//   PCF                 current fetch address
//   InstrD, PC4D, ExcCodeD   registered outputs to decode
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = fetch_stage_pkg::PC_RESET,
  parameter logic [31:0] EXC_ENTRY = fetch_stage_pkg::EXC_ENTRY,
  parameter logic [31:0] IM_LO     = fetch_stage_pkg::IM_LO,
  parameter logic [31:0] IM_HI     = fetch_stage_pkg::IM_HI
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] InstrF,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] NPCOut,
  input  logic [31:0] ForwardD1,
  input  logic        Stall,
  input  logic        ExcEnter,
  input  logic        Eret,
  input  logic [31:0] EPC,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PC4D,
  output logic [6:2]  ExcCodeD
);

  import fetch_stage_pkg::*;

  logic [31:0]      r_pc;
  logic [31:0]      w_pc4;
  logic [31:0]      w_next_pc;
  logic             w_adel;
  logic             w_flush;
  logic [31:0]      w_instr_in;
  logic [EXC_W-1:0] w_exc_in;
  logic [EXC_W-1:0] w_exc_out;

  assign w_pc4 = r_pc + 32'd4;

  // Bad targets are not rejected here; they surface as AdEL on the fetch itself.
  assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < IM_LO) || (r_pc > IM_HI);

  always_comb begin
    w_next_pc = w_pc4;
    case (PCSrc)
      PCSRC_NPC: w_next_pc = NPCOut;
      PCSRC_REG: w_next_pc = ForwardD1;
      default:   w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc <= PC_RESET;
    end else if (ExcEnter) begin
      r_pc <= EXC_ENTRY;
    end else if (Eret) begin
      r_pc <= EPC;
    end else if (!Stall) begin
      r_pc <= w_next_pc;
    end
  end

  assign w_flush    = ExcEnter || Eret;
  assign w_instr_in = w_adel ? 32'd0 : InstrF;
  assign w_exc_in   = w_adel ? EXC_ADEL : EXC_NONE;

  fd_reg u_fd_reg (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_flush (w_flush),
    .i_stall (Stall),
    .i_instr (w_instr_in),
    .i_pc4   (w_pc4),
    .i_exc   (w_exc_in),
    .o_instr (InstrD),
    .o_pc4   (PC4D),
    .o_exc   (w_exc_out)
  );

  assign PCF      = r_pc;
  assign ExcCodeD = w_exc_out;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, selects the next PC from decode's branch/jump/register-target requests and from the CP0 exception/eret controls, and checks fetch addresses for AdEL. It also owns the F/D pipeline register that produces `InstrD`, `PC4D` and `ExcCodeD` for decode.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_3000: PC value after reset.
- `EXC_ENTRY`, default 32'h0000_4180: exception handler entry.
- `IM_LO`, default 32'h0000_3000: lowest legal fetch address, inclusive.
- `IM_HI`, default 32'h0000_6FFC: highest legal fetch address, inclusive.

Ports:
- `Clk` input 1: clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `InstrF` input 32: instruction word from external IM at `PCF`; combinational read.
- `PCSrc` input 2: from decode. 0 = PC+4, 1 = `NPCOut`, 2 = `ForwardD1` (jr/jalr), 3 = PC+4.
- `NPCOut` input 32: branch/jump target from decode.
- `ForwardD1` input 32: forwarded rs value, used as the register jump target.
- `Stall` input 1: hold PC and the F/D register.
- `ExcEnter` input 1: CP0 takes an exception or interrupt this cycle.
- `Eret` input 1: eret is committing this cycle.
- `EPC` input 32: return address for eret.
- `PCF` output 32: current fetch address, to IM and CP0.
- `InstrD` output 32: registered instruction to decode.
- `PC4D` output 32: registered PCF+4 to decode.
- `ExcCodeD` output 5 (bits [6:2]): registered fetch exception code to decode.

## Operation
- Fetch check: `AdEL_F` = (`PCF`[1:0] != 0) or (`PCF` < `IM_LO`) or (`PCF` > `IM_HI`).
- Next-PC selection per `PCSrc`. All additions are 32-bit and wrap modulo 2^32.
- PC register update priority, evaluated each rising edge:
  - `Reset`: `PCF` ← `PC_RESET`.
  - `ExcEnter`: `PCF` ← `EXC_ENTRY`.
  - `Eret`: `PCF` ← `EPC`.
  - `Stall`: `PCF` holds.
  - Otherwise: `PCF` ← selected next PC.
- F/D register, same priority order:
  - `Reset`: all fields cleared.
  - `ExcEnter` or `Eret`: flush; `InstrD` ← 0 (nop), `PC4D` ← 0, `ExcCodeD` ← 0.
  - `Stall`: hold.
  - Otherwise, with `AdEL_F`: `InstrD` ← 0, `PC4D` ← `PCF`+4, `ExcCodeD` ← 5'd4.
  - Otherwise, without `AdEL_F`: `InstrD` ← `InstrF`, `PC4D` ← `PCF`+4, `ExcCodeD` ← 0.
- `ExcEnter` and `Eret` both asserted in one cycle: `ExcEnter` wins.
- `Stall` together with `ExcEnter` or `Eret`: the redirect and flush win.
- The branch delay slot is fetched normally. A redirect from decode takes effect on the PC after the delay-slot fetch, which is implicit in the decode-stage timing.
- A misaligned or out-of-range `EPC` or jump target is not faulted at selection time. It becomes `AdEL_F` at the next fetch.

## Timing
- Reset values: `PCF` = `PC_RESET`, `InstrD` = 0, `PC4D` = 0, `ExcCodeD` = 0.
- `PCF` changes only on a clock edge. `InstrF` must be valid combinationally from `PCF` in the same cycle.
- F→D latency is 1 cycle. A redirect is visible on `PCF` one edge after the request.
- No combinational path from any input to any output.
- A stall of any length holds all outputs bit-exact. Release resumes from the held PC with no lost or duplicated fetch.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge.

## Structure
- Shared package constants: `PC_RESET`, `EXC_ENTRY`, `IM_LO`, `IM_HI`, `EXC_ADEL` = 5'd4, and the `PCSrc` encodings (`PCSRC_PC4`, `PCSRC_NPC`, `PCSRC_REG`).
- One sub-module: `fd_reg`, the F/D pipeline register with stall/flush priority, reused pattern for later pipeline registers. PC register, next-PC mux and AdEL check live in `fetch_stage`.

## Test plan
- Reset, then 3 free-running cycles with no stall → `PCF` goes 0x3000, 0x3004, 0x3008; `PC4D` = 0x3004 one cycle after fetching 0x3000.
- `PCSrc`=1 with `NPCOut`=0x3100, then `PCSrc`=2 with `ForwardD1`=0x3200 → next `PCF` = 0x3100, then 0x3200.
- `Stall` held 3 cycles at `PCF`=0x3010 → `PCF`, `InstrD`, `PC4D` unchanged for 3 cycles; after release `PCF`=0x3014.
- Jump to 0x3002, then jump to 0x7000 → each fetch yields `InstrD`=0, `ExcCodeD`=4, `PC4D`=target+4.
- `ExcEnter` and `Stall` together → `PCF`=0x4180, `InstrD`=0; with `Eret` also high, `ExcEnter` still wins. Next cycle `Eret` with `EPC`=0x3020 → `PCF`=0x3020, D flushed.
- `Reset` asserted during a stall at 0x3040 → next `PCF`=0x3000 and all D outputs 0.
